// File: rtl/fb_gamma_write_pipe.sv
// Two-stage framebuffer write pipe with per-channel gamma LUTs.
// Flags frame_done when the last pixel address leaves the pipe.
module fb_gamma_write_pipe #(
  parameter int N_ROWS_MAX   = 64,
  parameter int N_COLS_MAX   = 256,
  parameter int BITDEPTH_MAX = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = $clog2(N_ROWS_MAX * N_COLS_MAX)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ctrl_gamma_en,
  input  logic                    lut_we,
  input  logic [1:0]              lut_sel,
  input  logic [BITDEPTH_MAX-1:0] lut_addr,
  input  logic [BITDEPTH_MAX-1:0] lut_wdata,
  input  logic                    in_we,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic [DATA_WIDTH-1:0]   in_wdata,
  input  logic [DATA_WIDTH/8-1:0] in_wstrb,
  output logic                    out_we,
  output logic [ADDR_WIDTH-1:0]   out_addr,
  output logic [DATA_WIDTH-1:0]   out_wdata,
  output logic [DATA_WIDTH/8-1:0] out_wstrb,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int BD    = BITDEPTH_MAX;
  localparam int DEPTH = 1 << BD;
  localparam int SW    = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(N_ROWS_MAX * N_COLS_MAX - 1);

  typedef logic [BD-1:0] lut_t [DEPTH];

  function automatic lut_t identity();
    lut_t t;
    for (int i = 0; i < DEPTH; i++) t[i] = BD'(i);
    return t;
  endfunction

  // Power-up contents are the identity map; never cleared by rst.
  lut_t lut_b = identity();
  lut_t lut_g = identity();
  lut_t lut_r = identity();

  logic [BD-1:0] rd_b, rd_g, rd_r;

  logic                  s1_v;
  logic                  s1_ge;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [SW-1:0]         s1_strb;
  logic [DATA_WIDTH-1:0] corr;

  // Read-first: a same-edge write is seen by the following lookup.
  always_ff @(posedge clk) begin
    if (lut_we) begin
      case (lut_sel)
        2'd0:    lut_b[lut_addr] <= lut_wdata;
        2'd1:    lut_g[lut_addr] <= lut_wdata;
        2'd2:    lut_r[lut_addr] <= lut_wdata;
        default: ;
      endcase
    end
    rd_b <= lut_b[in_wdata[0 +: BD]];
    rd_g <= lut_g[in_wdata[BD +: BD]];
    rd_r <= lut_r[in_wdata[2*BD +: BD]];
  end

  always_comb begin
    corr = s1_data;
    corr[0 +: BD]    = rd_b;
    corr[BD +: BD]   = rd_g;
    corr[2*BD +: BD] = rd_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_ge   <= 1'b0;
      s1_addr <= '0;
      s1_data <= '0;
      s1_strb <= '0;
    end else begin
      s1_v <= in_we;
      if (in_we) begin
        s1_ge   <= ctrl_gamma_en;
        s1_addr <= in_addr;
        s1_data <= in_wdata;
        s1_strb <= in_wstrb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_we     <= 1'b0;
      out_addr   <= '0;
      out_wdata  <= '0;
      out_wstrb  <= '0;
      frame_done <= 1'b0;
    end else begin
      out_we     <= s1_v;
      frame_done <= s1_v && (s1_addr == LAST);
      if (s1_v) begin
        out_addr  <= s1_addr;
        out_wdata <= s1_ge ? corr : s1_data;
        out_wstrb <= s1_strb;
      end
    end
  end

  assign busy = s1_v | out_we;

endmodule
